// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and IF/ID: buffers {pc, instr} pairs,
// optional same-cycle bypass when empty, single-cycle flush, NOP bubble when idle.
module fetch_queue #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 4,
  parameter bit               BYPASS = 1'b0,
  parameter logic [WIDTH-1:0] NOP    = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_pc,
  input  logic [WIDTH-1:0]           enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_pc,
  output logic [WIDTH-1:0]           deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [WIDTH-1:0] r_mem_instr [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pass;
  logic w_enq;
  logic w_deq;
  logic w_store;
  logic w_adv;

  assign w_empty = (r_count == {CW{1'b0}});
  assign w_full  = (r_count == FULL_CNT);
  // Bypass only applies to an empty queue; a flush cycle shows nothing.
  assign w_pass  = BYPASS && w_empty && enq_valid && !flush;

  assign enq_ready = !w_full && !flush;
  assign w_enq     = enq_valid && enq_ready;
  assign w_deq     = deq_valid && deq_ready;
  assign w_store   = w_enq && !(w_pass && deq_ready);
  assign w_adv     = w_deq && !w_empty;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  always_comb begin
    deq_valid = 1'b0;
    deq_pc    = {WIDTH{1'b0}};
    deq_instr = NOP;
    if (flush) begin
      deq_valid = 1'b0;
    end else if (!w_empty) begin
      deq_valid = 1'b1;
      deq_pc    = r_mem_pc[r_rd_ptr];
      deq_instr = r_mem_instr[r_rd_ptr];
    end else if (w_pass) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end else begin
      deq_valid = 1'b0;
    end
  end

  // Storage array carries no reset; only entries inside [rd_ptr, wr_ptr) are ever read.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_pc[r_wr_ptr]    <= enq_pc;
      r_mem_instr[r_wr_ptr] <= enq_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_adv) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_store, w_adv})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
